// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: runtime-programmable clock divider with period-aligned ratio changes
// and clean start/stop on en.
module clk_div_ctrl #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 4
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [WIDTH-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             clk_out,
   output logic             tick,
   output logic [WIDTH-1:0] cur_div
);
   typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;
   localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);
   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d, cur_div_q, cur_div_d, pend_q, pend_d;
   logic             clk_out_q, clk_out_d, tick_q, tick_d, cfg_err_q, cfg_err_d;
   logic             xfer, take, bnd;
   assign cfg_ready = !rst && state_q != PEND;
   assign xfer      = cfg_valid && cfg_ready;
   assign take      = xfer && cfg_div >= WIDTH'(2);
   assign bnd       = state_q != IDLE && cnt_q == cur_div_q - WIDTH'(1);
   assign clk_out   = clk_out_q;
   assign tick      = tick_q;
   assign cfg_err   = cfg_err_q;
   assign cur_div   = cur_div_q;
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cur_div_d = cur_div_q;
      pend_d    = pend_q;
      cfg_err_d = xfer && !take;
      if (state_q == IDLE) begin
         cnt_d = '0;
         if (take) cur_div_d = cfg_div;
         if (en) state_d = RUN;
      end else if (bnd) begin
         cnt_d = '0;
         if (state_q == PEND) cur_div_d = pend_q;
         if (take) pend_d = cfg_div;
         // stopping at this boundary: a ratio taken now applies directly, as in IDLE
         if (!en) begin
            state_d = IDLE;
            if (take) cur_div_d = cfg_div;
         end else begin
            state_d = take ? PEND : RUN;
         end
      end else begin
         cnt_d = cnt_q + WIDTH'(1);
         if (take) begin
            state_d = PEND;
            pend_d  = cfg_div;
         end
      end
      // outputs are registered from next-state so they line up with cnt_q
      clk_out_d = state_d != IDLE && cnt_d < (cur_div_d >> 1);
      tick_d    = state_d != IDLE && cnt_d == '0;
   end
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         cur_div_q <= DEF;
         pend_q    <= '0;
         clk_out_q <= 1'b0;
         tick_q    <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cur_div_q <= cur_div_d;
         pend_q    <= pend_d;
         clk_out_q <= clk_out_d;
         tick_q    <= tick_d;
         cfg_err_q <= cfg_err_d;
      end
   end
endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Runtime-programmable clock-divider controller. Sequences a counter-based divider from `clk_in`, accepts new divide ratios over a valid/ready configuration port, and applies each ratio only at a period boundary so `clk_out` never shows a truncated or runt period. It also starts and stops the divided clock cleanly on `en`. It sits between the register/config logic and the clock consumers that previously used fixed-ratio dividers.

## Interface
- `WIDTH`, 8: width of divide ratio and internal counter
- `DEFAULT_DIV`, 4: ratio loaded at reset; must be ≥2 and <2^WIDTH

- `clk_in`  in  1  source clock; all logic on its rising edge
- `rst`  in  1  reset, synchronous, active-high
- `en`  in  1  run request; level-sensitive
- `cfg_valid`  in  1  new ratio offered
- `cfg_div`  in  WIDTH  offered ratio, meaningful when `cfg_valid`=1
- `cfg_ready`  out  1  controller can accept a ratio this cycle
- `cfg_err`  out  1  one-cycle pulse: accepted ratio was illegal (<2) and discarded
- `clk_out`  out  1  divided clock, registered
- `tick`  out  1  one-cycle pulse in the first `clk_in` cycle of each output period
- `cur_div`  out  WIDTH  ratio currently in effect

## Operation
- States: IDLE (stopped), RUN (dividing, nothing pending), PEND (dividing, one ratio waiting).
- Counter `cnt` runs 0..cur_div-1, then wraps. The boundary is a RUN/PEND cycle with `cnt`==cur_div-1.
- `clk_out` is high exactly when `cnt` < floor(cur_div/2) in RUN/PEND, and low in IDLE. Even ratios give 50% duty; odd ratios give high for (N-1)/2 cycles.
- Handshake: transfer occurs when `cfg_valid`&&`cfg_ready`. `cfg_ready` = !rst && state!=PEND. `cfg_valid`/`cfg_div` are held by the source until transfer.
- Illegal ratio (0 or 1): transferred, discarded, `cfg_err`=1 the next cycle, state and `cur_div` unchanged.
- Legal transfer in IDLE: `cur_div` updates next cycle, state stays IDLE.
- Legal transfer in RUN: ratio is latched, and state goes to PEND.
- At a boundary in PEND: `cur_div` takes the latched ratio, `cnt` goes to 0, and state goes to RUN (or IDLE if `en`=0).
- A transfer in the boundary cycle itself goes to PEND and applies at the following boundary.
- IDLE with `en`=1: next cycle is RUN with `cnt`=0.
- `en`=0 in RUN/PEND: the current period completes. At the boundary the state goes to IDLE and any pending ratio is applied. If `en` returns to 1 before the boundary, running continues uninterrupted.
- Wrap in RUN with `en`=1: `cnt` goes to 0 and `tick` fires.

## Timing
- Reset values: state IDLE, `cnt`=0, `cur_div`=DEFAULT_DIV, `clk_out`=0, `tick`=0, `cfg_err`=0. `cfg_ready`=0 while `rst`=1 and 1 in the first cycle after.
- `rst` has priority over every other input. Reset mid-period drops `clk_out` low in the next cycle, clears any pending ratio, and restores DEFAULT_DIV.
- Start latency: `en` sampled high in IDLE at cycle T gives `clk_out`=1 and `tick`=1 at T+1.
- Stop: `clk_out` is low from the cycle after the boundary. The last period is always full length.
- Ratio change: the first period at the new ratio starts the cycle after the boundary. `tick` marks it, and `cur_div` is updated in that same cycle.
- `cfg_ready` stays 0 from the cycle after a RUN transfer through the boundary cycle, and returns to 1 the cycle after the boundary.
- `tick` and `cfg_err` are single-cycle, and both may assert in the same cycle.

## Test plan
- Reset, `en`=1, DEFAULT_DIV=4 → `clk_out` repeats 1,1,0,0 starting the cycle after `en`, with `tick` every 4 cycles and `cur_div`=4.
- Configure 5 in IDLE, then `en`=1 → `clk_out` repeats 1,1,0,0,0, with no `cfg_err`.
- Running at 4, offer 6 when `cnt`=1 → remaining 2 cycles at ratio 4, then `clk_out` repeats 1,1,1,0,0,0. `cfg_ready` is low until the boundary, and a second offer of 2 is held off and then applies one period later.
- Offer 1 and then 0 while running at 4 → two `cfg_err` pulses, `cur_div` stays 4, and the pattern is undisturbed.
- Running at 8, drop `en` at `cnt`=2 → `clk_out` finishes the period (high cnt 0–3, low cnt 4–7), then stays low; state is IDLE.
- Running at 6 with a pending ratio of 10, assert `rst` at `cnt`=3 → next cycle `clk_out`=0, `cur_div`=4, no pending ratio. After `en`, the 4-cycle pattern resumes.
